// File: rtl/mpu_matrix_loader.sv
// Operand loader for the matrix processing unit: assembles two 5x5 byte
// matrices (A then B) from an element stream and hands them off as a pair.
//
// state  | meaning
// LOAD_A | accepting elements into matrix_a slot count
// LOAD_B | accepting elements into matrix_b slot count
// HOLD   | both operands complete and frozen, waiting for out_ready
module mpu_matrix_loader (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [199:0] matrix_a,
  output logic [199:0] matrix_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         loading_b,
  output logic [4:0]   count
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [4:0]     count_q;
  logic [199:0]   matrix_a_q;
  logic [199:0]   matrix_b_q;
  logic           in_fire;
  logic           out_fire;
  logic           last_slot;
  logic [7:0]     slot_lsb;

  // Handshake qualifiers depend only on registered state, never on the
  // incoming valid/ready, so there is no combinational loop to the neighbours.
  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == HOLD);
  assign loading_b = (state == LOAD_B);
  assign count     = count_q;
  assign matrix_a  = matrix_a_q;
  assign matrix_b  = matrix_b_q;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_slot = (count_q == 5'd24);
  assign slot_lsb  = {count_q, 3'b000};

  always_comb begin
    state_next = state;
    case (state)
      LOAD_A:  if (in_fire && last_slot) state_next = LOAD_B;
      LOAD_B:  if (in_fire && last_slot) state_next = HOLD;
      HOLD:    if (out_fire) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= 5'd0;
    end else if (in_fire) begin
      count_q <= last_slot ? 5'd0 : count_q + 5'd1;
    end
  end

  // clear keeps the matrix contents; only reset zeroes them.
  always_ff @(posedge clock) begin
    if (reset) begin
      matrix_a_q <= '0;
      matrix_b_q <= '0;
    end else if (!clear && in_fire) begin
      if (state == LOAD_A) begin
        matrix_a_q[slot_lsb +: 8] <= in_data;
      end else begin
        matrix_b_q[slot_lsb +: 8] <= in_data;
      end
    end
  end

endmodule
